// File: rtl/tic_tac_referee.sv
// Tic-tac-toe referee: takes human moves, queries the move engine, owns the board and declares the result.
// Optional feature macro: TIC_TAC_AUTO_RESTART_EN (square 0 offered in DONE/ERROR starts a new game).
module tic_tac_referee #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       h_valid_i,
    input  logic [3:0] h_square_i,
    output logic       h_ready_o,
    output logic       eng_req_o,
    output logic [3:0] eng_hmove_o,
    input  logic       eng_ack_i,
    input  logic [3:0] eng_cmove_i,
    output logic [8:0] board_x_o,
    output logic [8:0] board_o_o,
    output logic       human_win_o,
    output logic       comp_win_o,
    output logic       draw_o,
    output logic       illegal_o,
    output logic       eng_err_o,
    output logic [2:0] state_o
);

    // Handshakes: a human move transfers on a rising edge with h_valid_i && h_ready_o;
    // an engine reply transfers on a rising edge with eng_ack_i && eng_req_o. Anything else is ignored.
    typedef enum logic [2:0] {
        ST_WAIT_H  = 3'd0,
        ST_REQ_ENG = 3'd1,
        ST_CHECK   = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state_q;
    logic [8:0] board_x_q, board_o_q;
    logic [3:0] eng_hmove_q;
    logic [7:0] timer_q;
    logic       human_win_q, comp_win_q, draw_q, illegal_q, eng_err_q;

    logic [8:0] h_mask, e_mask, occupied;
    logic [8:0] board_x_d, board_o_d;
    logic       h_legal, e_legal;

    function automatic logic [8:0] sq_mask(input logic [3:0] sq);
        sq_mask = 9'd0;
        if (sq >= 4'd1 && sq <= 4'd9) begin
            sq_mask = 9'd1 << (sq - 4'd1);
        end
    endfunction

    function automatic logic has_line(input logic [8:0] b);
        has_line = (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8])
                 | (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8])
                 | (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
    endfunction

    always_comb begin
        occupied  = board_x_q | board_o_q;
        h_mask    = sq_mask(h_square_i);
        e_mask    = sq_mask(eng_cmove_i);
        h_legal   = (h_mask != 9'd0) && ((h_mask & occupied) == 9'd0);
        e_legal   = (e_mask != 9'd0) && ((e_mask & occupied) == 9'd0);
        board_x_d = board_x_q | h_mask;
        board_o_d = board_o_q | e_mask;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_WAIT_H;
            board_x_q   <= 9'd0;
            board_o_q   <= 9'd0;
            eng_hmove_q <= 4'd0;
            timer_q     <= 8'd0;
            human_win_q <= 1'b0;
            comp_win_q  <= 1'b0;
            draw_q      <= 1'b0;
            illegal_q   <= 1'b0;
            eng_err_q   <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            case (state_q)
                ST_WAIT_H: begin
                    if (h_valid_i) begin
                        if (!h_legal) begin
                            illegal_q <= 1'b1;
                        end else begin
                            board_x_q   <= board_x_d;
                            eng_hmove_q <= h_square_i;
                            timer_q     <= 8'd0;
                            if (has_line(board_x_d)) begin
                                human_win_q <= 1'b1;
                                state_q     <= ST_DONE;
                            end else if (&(board_x_d | board_o_q)) begin
                                draw_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end else begin
                                state_q <= ST_REQ_ENG;
                            end
                        end
                    end
                end
                ST_REQ_ENG: begin
                    // A reply arriving on the timeout cycle still counts as a reply.
                    if (eng_ack_i) begin
                        if (e_legal) begin
                            board_o_q <= board_o_d;
                            state_q   <= ST_CHECK;
                        end else begin
                            eng_err_q <= 1'b1;
                            state_q   <= ST_ERROR;
                        end
                    end else if (timer_q == TIMER_LAST) begin
                        eng_err_q <= 1'b1;
                        state_q   <= ST_ERROR;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                ST_CHECK: begin
                    timer_q <= 8'd0;
                    if (has_line(board_o_q)) begin
                        comp_win_q <= 1'b1;
                        state_q    <= ST_DONE;
                    end else if (&occupied) begin
                        draw_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_WAIT_H;
                    end
                end
                ST_DONE, ST_ERROR: begin
`ifdef TIC_TAC_AUTO_RESTART_EN
                    if (h_valid_i && h_square_i == 4'd0) begin
                        state_q     <= ST_WAIT_H;
                        board_x_q   <= 9'd0;
                        board_o_q   <= 9'd0;
                        eng_hmove_q <= 4'd0;
                        timer_q     <= 8'd0;
                        human_win_q <= 1'b0;
                        comp_win_q  <= 1'b0;
                        draw_q      <= 1'b0;
                        eng_err_q   <= 1'b0;
                    end
`endif
                end
                default: state_q <= ST_ERROR;
            endcase
        end
    end

`ifdef TIC_TAC_AUTO_RESTART_EN
    assign h_ready_o = (state_q == ST_WAIT_H) || (state_q == ST_DONE) || (state_q == ST_ERROR);
`else
    assign h_ready_o = (state_q == ST_WAIT_H);
`endif
    assign eng_req_o   = (state_q == ST_REQ_ENG);
    assign eng_hmove_o = eng_hmove_q;
    assign board_x_o   = board_x_q;
    assign board_o_o   = board_o_q;
    assign human_win_o = human_win_q;
    assign comp_win_o  = comp_win_q;
    assign draw_o      = draw_q;
    assign illegal_o   = illegal_q;
    assign eng_err_o   = eng_err_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_tic_tac_referee.sv
// Directed game scripts for tic_tac_referee; a reference model pushes expected snapshots into a queue
// that is popped and compared after every clock edge.
module tb_tic_tac_referee;

    localparam int TIMEOUT = 15;
    localparam logic [8:0] LINES [8] = '{9'h007, 9'h038, 9'h1C0, 9'h049, 9'h092, 9'h124, 9'h111, 9'h054};

    logic       clock_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       h_valid_i = 1'b0;
    logic [3:0] h_square_i = 4'd0;
    logic       eng_ack_i = 1'b0;
    logic [3:0] eng_cmove_i = 4'd0;
    logic       h_ready_o, eng_req_o, human_win_o, comp_win_o, draw_o, illegal_o, eng_err_o;
    logic [3:0] eng_hmove_o;
    logic [8:0] board_x_o, board_o_o;
    logic [2:0] state_o;

    always #5 clock_i = ~clock_i;

    tic_tac_referee #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .h_valid_i(h_valid_i), .h_square_i(h_square_i), .h_ready_o(h_ready_o),
        .eng_req_o(eng_req_o), .eng_hmove_o(eng_hmove_o),
        .eng_ack_i(eng_ack_i), .eng_cmove_i(eng_cmove_i),
        .board_x_o(board_x_o), .board_o_o(board_o_o),
        .human_win_o(human_win_o), .comp_win_o(comp_win_o), .draw_o(draw_o),
        .illegal_o(illegal_o), .eng_err_o(eng_err_o), .state_o(state_o)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    logic [8:0] m_x, m_o;
    logic [3:0] m_hmove;
    logic [2:0] m_state;
    logic       m_hw, m_cw, m_draw, m_ill, m_err;
    int         m_cnt;

    function automatic logic [8:0] sq_mask(input logic [3:0] sq);
        logic [8:0] m;
        m = 9'd0;
        if (sq >= 4'd1 && sq <= 4'd9) m = 9'(1) << (int'(sq) - 1);
        return m;
    endfunction

    function automatic logic line_in(input logic [8:0] b);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 8; i++) if ((b & LINES[i]) == LINES[i]) r = 1'b1;
        return r;
    endfunction

    function automatic logic m_ready();
`ifdef TIC_TAC_AUTO_RESTART_EN
        return (m_state == 3'd0) || (m_state == 3'd3) || (m_state == 3'd4);
`else
        return (m_state == 3'd0);
`endif
    endfunction

    function automatic logic [31:0] model_snap();
        return {m_hmove, m_state, m_x, m_o, m_hw, m_cw, m_draw, m_ill, m_err, (m_state == 3'd1), m_ready()};
    endfunction

    function automatic logic [31:0] dut_snap();
        return {eng_hmove_o, state_o, board_x_o, board_o_o, human_win_o, comp_win_o, draw_o,
                illegal_o, eng_err_o, eng_req_o, h_ready_o};
    endfunction

    task automatic model_clear();
        m_x = 9'd0; m_o = 9'd0; m_hmove = 4'd0; m_state = 3'd0;
        m_hw = 1'b0; m_cw = 1'b0; m_draw = 1'b0; m_ill = 1'b0; m_err = 1'b0; m_cnt = 0;
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check_snap(input string tag);
        logic [31:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check_val(tag, dut_snap(), e);
    endtask

    // One clock edge: advance the model, drive the inputs, then compare after the edge.
    task automatic do_cycle(input logic hv, input logic [3:0] hsq, input logic ack,
                            input logic [3:0] csq, input string tag);
        logic [8:0] mk;
        m_ill = 1'b0;
        case (m_state)
            3'd0: if (hv) begin
                mk = sq_mask(hsq);
                if (mk == 9'd0 || ((m_x | m_o) & mk) != 9'd0) m_ill = 1'b1;
                else begin
                    m_x = m_x | mk; m_hmove = hsq; m_cnt = 0;
                    if (line_in(m_x)) begin m_hw = 1'b1; m_state = 3'd3; end
                    else if ((m_x | m_o) == 9'h1FF) begin m_draw = 1'b1; m_state = 3'd3; end
                    else m_state = 3'd1;
                end
            end
            3'd1: if (ack) begin
                mk = sq_mask(csq);
                if (mk != 9'd0 && ((m_x | m_o) & mk) == 9'd0) begin m_o = m_o | mk; m_state = 3'd2; end
                else begin m_err = 1'b1; m_state = 3'd4; end
            end else begin
                m_cnt++;
                if (m_cnt >= TIMEOUT) begin m_err = 1'b1; m_state = 3'd4; end
            end
            3'd2: begin
                m_cnt = 0;
                if (line_in(m_o)) begin m_cw = 1'b1; m_state = 3'd3; end
                else if ((m_x | m_o) == 9'h1FF) begin m_draw = 1'b1; m_state = 3'd3; end
                else m_state = 3'd0;
            end
            default: begin
`ifdef TIC_TAC_AUTO_RESTART_EN
                if (hv && hsq == 4'd0) model_clear();
`endif
            end
        endcase
        h_valid_i = hv; h_square_i = hsq; eng_ack_i = ack; eng_cmove_i = csq;
        exp_q.push_back(model_snap());
        @(negedge clock_i);
        h_valid_i = 1'b0; h_square_i = 4'd0; eng_ack_i = 1'b0; eng_cmove_i = 4'd0;
        check_snap(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 4'd0, 1'b0, 4'd0, tag);
    endtask

    task automatic human(input logic [3:0] sq, input string tag);
        do_cycle(1'b1, sq, 1'b0, 4'd0, tag);
        if (m_ill) do_cycle(1'b0, 4'd0, 1'b0, 4'd0, {tag, "_drop"});
    endtask

    task automatic engine(input logic [3:0] sq, input int delay, input string tag);
        idle(delay, {tag, "_wait"});
        do_cycle(1'b0, 4'd0, 1'b1, sq, tag);
        if (m_state == 3'd2) do_cycle(1'b0, 4'd0, 1'b0, 4'd0, {tag, "_chk"});
    endtask

    task automatic reset_dut(input string tag);
        reset_i = 1'b1;
        #1;
        model_clear();
        exp_q.push_back(model_snap());
        check_snap(tag);
        @(negedge clock_i);
        reset_i = 1'b0;
    endtask

    initial begin
        model_clear();
        reset_dut("reset");

        // T1 human win, with random engine latency
        human(4'd1, "t1_x1"); engine(4'd5, $urandom_range(0, 4), "t1_o5");
        human(4'd2, "t1_x2"); engine(4'd9, $urandom_range(0, 4), "t1_o9");
        human(4'd3, "t1_x3");
        check_val("t1_board_x", 32'(board_x_o), 32'h007);
        check_val("t1_board_o", 32'(board_o_o), 32'h110);
        check_val("t1_state", 32'(state_o), 32'd3);
        check_val("t1_hwin", 32'(human_win_o), 32'd1);
        human(4'd4, "t1_done_hvalid");
        do_cycle(1'b0, 4'd0, 1'b1, 4'd6, "t1_done_ack");

        // T2 computer win
        reset_dut("t2_reset");
        human(4'd1, "t2_x1"); engine(4'd5, $urandom_range(0, 4), "t2_o5");
        human(4'd2, "t2_x2"); engine(4'd3, $urandom_range(0, 4), "t2_o3");
        human(4'd9, "t2_x9"); engine(4'd7, 0, "t2_o7");
        check_val("t2_board_x", 32'(board_x_o), 32'h103);
        check_val("t2_board_o", 32'(board_o_o), 32'h054);
        check_val("t2_cwin", 32'(comp_win_o), 32'd1);

        // T3 draw
        reset_dut("t3_reset");
        human(4'd1, "t3_x1"); engine(4'd5, 1, "t3_o5");
        human(4'd9, "t3_x9"); engine(4'd2, 0, "t3_o2");
        human(4'd8, "t3_x8"); engine(4'd7, 2, "t3_o7");
        human(4'd3, "t3_x3"); engine(4'd6, 0, "t3_o6");
        human(4'd4, "t3_x4");
        check_val("t3_board_x", 32'(board_x_o), 32'h18D);
        check_val("t3_board_o", 32'(board_o_o), 32'h072);
        check_val("t3_draw", 32'(draw_o), 32'd1);
        idle(2, "t3_no_req");

        // T4 illegal human squares, and h_valid ignored while waiting on the engine
        reset_dut("t4_reset");
        human(4'd1, "t4_x1"); engine(4'd5, 0, "t4_o5");
        human(4'd0, "t4_sq0");
        human(4'd10, "t4_sq10");
        human(4'd5, "t4_sq5_occ");
        check_val("t4_board_x", 32'(board_x_o), 32'h001);
        check_val("t4_board_o", 32'(board_o_o), 32'h010);
        check_val("t4_state", 32'(state_o), 32'd0);
        human(4'd2, "t4_x2");
        do_cycle(1'b1, 4'd4, 1'b0, 4'd0, "t4_hvalid_in_req");
        check_val("t4_hmove", 32'(eng_hmove_o), 32'd2);
        engine(4'd6, 0, "t4_o6");

        // T5 engine faults
        reset_dut("t5_reset_a");
        human(4'd1, "t5_x1");
        idle(TIMEOUT, "t5_timeout");
        check_val("t5_err", 32'(eng_err_o), 32'd1);
        check_val("t5_state", 32'(state_o), 32'd4);
        check_val("t5_req", 32'(eng_req_o), 32'd0);
        reset_dut("t5_reset_b");
        human(4'd1, "t5_x1b"); engine(4'd1, 0, "t5_occupied");
        check_val("t5_occ_err", 32'(eng_err_o), 32'd1);
        reset_dut("t5_reset_c");
        human(4'd1, "t5_x1c"); engine(4'd12, 0, "t5_range");
        reset_dut("t5_reset_d");
        human(4'd1, "t5_x1d"); engine(4'd5, TIMEOUT - 1, "t5_ack_at_limit");
        check_val("t5_limit_o", 32'(board_o_o), 32'h010);
        check_val("t5_limit_err", 32'(eng_err_o), 32'd0);

        // T6 asynchronous reset while the engine request is pending
        human(4'd3, "t6_x3");
        reset_i = 1'b1;
        #1;
        check_val("t6_req_async", 32'(eng_req_o), 32'd0);
        check_val("t6_boards_async", 32'({board_x_o, board_o_o}), 32'd0);
        reset_dut("t6_reset");

`ifdef TIC_TAC_AUTO_RESTART_EN
        human(4'd1, "r_x1"); engine(4'd5, 0, "r_o5");
        human(4'd2, "r_x2"); engine(4'd9, 0, "r_o9");
        human(4'd3, "r_x3");
        human(4'd7, "r_ignored");
        human(4'd0, "r_restart");
        check_val("r_state", 32'(state_o), 32'd0);
        check_val("r_flags", 32'({human_win_o, comp_win_o, draw_o, eng_err_o}), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
